// File: rtl/mem_access.sv
// mem_access: MEM pipeline stage and MEM/WB register.
// ALU results pass straight through to WB. Loads and stores go out on a
// req/ack data-memory bus, and the pipeline stalls while an access is in flight.
//
// Bus handshake: the block raises dm_req and holds dm_we/dm_addr/dm_sel/dm_wdata
// stable until the memory returns dm_ack=1 for one cycle. That cycle completes
// the access, and dm_rdata is sampled in it. dm_ack while dm_req=0 is ignored.
module mem_access #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  mem_wd,
    input  logic [31:0] mem_wdata,
    input  logic        mem_wreg,
    input  logic [3:0]  mem_op,
    input  logic [31:0] mem_sdata,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [3:0]  dm_sel,
    output logic [31:0] dm_wdata,
    input  logic [31:0] dm_rdata,
    input  logic        dm_ack,
    output logic        stall_req,
    output logic [4:0]  wb_wd,
    output logic [31:0] wb_wdata,
    output logic        wb_wreg,
    output logic        exc_adel,
    output logic        exc_ades,
    output logic        exc_buserr
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

    state_t      state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [4:0]  wb_wd_n;
    logic [31:0] wb_wdata_n;
    logic        wb_wreg_n, adel_n, ades_n, buserr_n;

    logic        is_load, is_store, is_byte, is_half, is_word, is_signed;
    logic        misaligned, start;
    logic [1:0]  off;
    logic [31:0] load_val;

    assign off = mem_wdata[1:0];

    // Decode the memory opcode into access kind and size.
    always_comb begin
        is_load   = 1'b0;
        is_store  = 1'b0;
        is_byte   = 1'b0;
        is_half   = 1'b0;
        is_word   = 1'b0;
        is_signed = 1'b0;
        case (mem_op)
            4'd1: begin is_load  = 1'b1; is_byte = 1'b1; is_signed = 1'b1; end
            4'd2: begin is_load  = 1'b1; is_byte = 1'b1; end
            4'd3: begin is_load  = 1'b1; is_half = 1'b1; is_signed = 1'b1; end
            4'd4: begin is_load  = 1'b1; is_half = 1'b1; end
            4'd5: begin is_load  = 1'b1; is_word = 1'b1; end
            4'd6: begin is_store = 1'b1; is_byte = 1'b1; end
            4'd7: begin is_store = 1'b1; is_half = 1'b1; end
            4'd8: begin is_store = 1'b1; is_word = 1'b1; end
            default: ;
        endcase
        misaligned = (is_half & off[0]) | (is_word & (off != 2'b00));
        start      = (is_load | is_store) & ~misaligned;
    end

    // Bus fields come from the held EX/MEM inputs; all zero when not requesting.
    always_comb begin
        dm_req   = rst & (((state == IDLE) & start) | (state == WAIT));
        dm_we    = 1'b0;
        dm_addr  = 32'h0;
        dm_sel   = 4'b0000;
        dm_wdata = 32'h0;
        if (dm_req) begin
            dm_we   = is_store;
            dm_addr = {mem_wdata[31:2], 2'b00};
            if (is_byte)      dm_sel = 4'b1000 >> off;
            else if (is_half) dm_sel = off[1] ? 4'b0011 : 4'b1100;
            else              dm_sel = 4'b1111;
            if (is_store) begin
                if (is_byte)      dm_wdata = {4{mem_sdata[7:0]}};
                else if (is_half) dm_wdata = {2{mem_sdata[15:0]}};
                else              dm_wdata = mem_sdata;
            end
        end
    end

    // Select and extend the addressed lane of the read word (offset 0 = MSB).
    always_comb begin
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'd0:    b = dm_rdata[31:24];
            2'd1:    b = dm_rdata[23:16];
            2'd2:    b = dm_rdata[15:8];
            default: b = dm_rdata[7:0];
        endcase
        h = off[1] ? dm_rdata[15:0] : dm_rdata[31:16];
        if (is_byte)      load_val = {{24{is_signed & b[7]}}, b};
        else if (is_half) load_val = {{16{is_signed & h[15]}}, h};
        else              load_val = dm_rdata;
    end

    // Next state, WB register inputs and exception pulses.
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        wb_wd_n    = 5'd0;
        wb_wdata_n = 32'h0;
        wb_wreg_n  = 1'b0;
        adel_n     = 1'b0;
        ades_n     = 1'b0;
        buserr_n   = 1'b0;
        stall_req  = 1'b0;
        case (state)
            IDLE: begin
                if (!(is_load | is_store)) begin
                    wb_wd_n    = mem_wd;
                    wb_wdata_n = mem_wdata;
                    wb_wreg_n  = mem_wreg;
                end else if (misaligned) begin
                    adel_n = is_load;
                    ades_n = is_store;
                end else if (dm_ack) begin
                    if (is_load) begin
                        wb_wd_n    = mem_wd;
                        wb_wdata_n = load_val;
                        wb_wreg_n  = mem_wreg;
                    end
                end else begin
                    stall_req = 1'b1;
                    state_n   = WAIT;
                    cnt_n     = CW'(1);
                end
            end
            WAIT: begin
                if (dm_ack) begin
                    if (is_load) begin
                        wb_wd_n    = mem_wd;
                        wb_wdata_n = load_val;
                        wb_wreg_n  = mem_wreg;
                    end
                    state_n = IDLE;
                    cnt_n   = '0;
                end else if (cnt == LAST) begin
                    buserr_n = 1'b1;
                    state_n  = IDLE;
                    cnt_n    = '0;
                end else begin
                    stall_req = 1'b1;
                    cnt_n     = cnt + CW'(1);
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
        if (!rst) stall_req = 1'b0;
    end

    // State register and MEM/WB pipeline register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            wb_wd      <= 5'd0;
            wb_wdata   <= 32'h0;
            wb_wreg    <= 1'b0;
            exc_adel   <= 1'b0;
            exc_ades   <= 1'b0;
            exc_buserr <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            wb_wd      <= wb_wd_n;
            wb_wdata   <= wb_wdata_n;
            wb_wreg    <= wb_wreg_n;
            exc_adel   <= adel_n;
            exc_ades   <= ades_n;
            exc_buserr <= buserr_n;
        end
    end

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- MEM pipeline stage fed directly by the EX/MEM register.
- Passes ALU results through to the MEM/WB boundary, or performs loads and stores over a req/ack data-memory bus.
- Stalls the pipeline while a bus access is outstanding.
- Outputs are registered, so this block also forms the MEM/WB pipeline register.

Parameters:
- TIMEOUT, 16, max cycles to wait for dm_ack before aborting with a bus error (min 2).

Ports:
- clk  in  1  clock, all state on posedge.
- rst  in  1  reset, synchronous, active-low.
- mem_wd  in  5 (`RegAddrBus)  destination register from EX/MEM.
- mem_wdata  in  32 (`RegBus)  ALU result; for loads and stores it is the effective address.
- mem_wreg  in  1  write-enable from EX/MEM.
- mem_op  in  4  0=pass, 1=LB, 2=LBU, 3=LH, 4=LHU, 5=LW, 6=SB, 7=SH, 8=SW; 9-15 are treated as pass.
- mem_sdata  in  32  store data (rt value).
- dm_req  out  1  bus request.
- dm_we  out  1  1=store.
- dm_addr  out  32  word address, {addr[31:2],2'b00}.
- dm_sel  out  4  byte-lane enables, big-endian (sel[3] = addr offset 0).
- dm_wdata  out  32  lane-replicated store data.
- dm_rdata  in  32  read data, valid when dm_ack=1.
- dm_ack  in  1  access complete.
- stall_req  out  1  holds EX/MEM and all upstream stages.
- wb_wd  out  5  to WB.
- wb_wdata  out  32  to WB.
- wb_wreg  out  1  to WB.
- exc_adel  out  1  1-cycle pulse, load address misaligned.
- exc_ades  out  1  1-cycle pulse, store address misaligned.
- exc_buserr  out  1  1-cycle pulse, bus timeout.

Behaviour:
- Reset (rst=0 at posedge):
  - state=IDLE, timeout counter=0.
  - wb_wd=0, wb_wdata=0, wb_wreg=0, all exc_* outputs = 0.
  - dm_req, dm_we, dm_addr, dm_sel, dm_wdata are combinational and are 0 while the state is IDLE after reset.
  - Reset in WAIT abandons the access: dm_req drops the next cycle and no WB write occurs.
- Alignment:
  - LH, LHU, SH need addr[0]=0.
  - LW, SW need addr[1:0]=0.
  - Byte ops are always aligned.
- Pass op, in IDLE:
  - No bus activity, stall_req=0.
  - At the next posedge wb_* <= mem_wd, mem_wdata, mem_wreg (latency 1).
- Misaligned op, in IDLE:
  - No dm_req, stall_req=0.
  - Next posedge: wb_wreg<=0, wb_wd/wb_wdata<=0.
  - exc_adel<=1 for a load or exc_ades<=1 for a store, for one cycle.
- Aligned memory op, in IDLE:
  - dm_req=1 combinationally in the same cycle; dm_we=1 for stores.
  - dm_sel: byte = 1000>>addr[1:0]; half = addr[1] ? 0011 : 1100; word = 1111.
  - dm_wdata: SB = {4{b}}, SH = {2{h}}, SW = word.
  - If dm_ack=1 in the same cycle (zero-wait): stall_req=0, result captured at the posedge, state stays IDLE.
  - Otherwise: stall_req=1, state→WAIT, counter=1.
- WAIT:
  - dm_req and all bus fields held, since the inputs are held by the stall.
  - stall_req = ~dm_ack, so it drops combinationally in the ack cycle.
  - On dm_ack: capture the result, state→IDLE, counter=0.
  - Without ack and counter==TIMEOUT-1: abort, stall_req=0 in that cycle, next posedge exc_buserr<=1, wb_wreg<=0, state→IDLE.
  - Otherwise: counter++.
- Load result:
  - The lane is selected by addr[1:0] from dm_rdata (offset 0 = bits 31:24).
  - LB and LH sign-extend; LBU and LHU zero-extend; LW takes the full word.
  - Captured as wb_wdata; wb_wd=mem_wd, wb_wreg=mem_wreg.
- Store completion: wb_wreg<=0, wb_wd<=0, wb_wdata<=0.
- While stall_req=1 and no completion that cycle: wb_wreg<=0, inserting a bubble into WB; wb_wd and wb_wdata also go to 0.
- dm_ack arriving in IDLE with no request is ignored.
- At most one access is outstanding; back-to-back memory ops each start in IDLE.

Test Plan:
- Reset then pass op: mem_wd=5, mem_wdata=0x1234, mem_wreg=1, mem_op=0 → next cycle wb_wd=5, wb_wdata=0x00001234, wb_wreg=1, dm_req=0 throughout; rst=0 for one edge → all wb_* outputs = 0.
- LB, zero wait: addr=0x1001, dm_ack=1 in the same cycle, dm_rdata=0x11AA2233 → dm_sel=0100, stall_req=0, next cycle wb_wdata=0xFFFFFFAA; the same access as LBU gives 0x000000AA.
- LW with 3 wait cycles: addr=0x2000, ack on the 4th request cycle, dm_rdata=0xDEADBEEF → stall_req=1 for 3 cycles then 0; wb_wreg=0 during the stall; then wb_wdata=0xDEADBEEF, wb_wreg=1.
- SH at addr 0x3002, sdata=0x0000BEEF → dm_we=1, dm_sel=0011, dm_wdata=0xBEEFBEEF, dm_addr=0x3000; after ack wb_wreg=0.
- Misaligned: LW at 0x2002 → no dm_req, exc_adel pulses 1 cycle, wb_wreg=0; SH at 0x3001 → exc_ades pulses 1 cycle.
- Timeout (TIMEOUT=16) and reset in WAIT: SW with no ack → stall_req high 15 cycles, exc_buserr pulses 1 cycle, back to IDLE; separately rst=0 while in WAIT → next cycle dm_req=0, stall_req=0, no WB write.
